// File: rtl/systolic_job_dispatcher_pkg.sv
// rtl/systolic_job_dispatcher_pkg.sv - shared types and constants for the job dispatcher
// Purpose: job record layout, dispatcher FSM states, status error codes and the legal-size helper.
// Ports: none (package).
package systolic_job_dispatcher_pkg;

    localparam int JOB_TAG_W = 4;
    localparam int ADDR_W    = 12;
    localparam int NSIZE_W   = 9;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_BAD_N   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        D_IDLE,
        D_LAUNCH,
        D_WAIT_CLR,
        D_RUN,
        D_REPORT
    } dispatch_state_t;

    // Tag width is fixed here; the top-level TAG_W must match JOB_TAG_W.
    typedef struct packed {
        logic [JOB_TAG_W-1:0] tag;
        logic [ADDR_W-1:0]    addr_a;
        logic [ADDR_W-1:0]    addr_b;
        logic [ADDR_W-1:0]    addr_c;
        logic [NSIZE_W-1:0]   n;
        logic                 step;
    } job_t;

    function automatic logic n_is_legal(input logic [NSIZE_W-1:0] n, input int max_n);
        return (n != '0) && (int'(n) <= max_n);
    endfunction

endpackage

// File: rtl/systolic_job_dispatcher_job_fifo.sv
// rtl/systolic_job_dispatcher_job_fifo.sv - synchronous FIFO of job records
// Purpose: DEPTH-entry job buffer between the host command port and the dispatcher FSM.
// Ports: clk, rst (async active-low); push/din write side; pop/dout read side (dout shows the head);
//        ready (registered, level<DEPTH), empty, level (registered occupancy), level_next (occupancy after this edge).
module job_fifo
    import systolic_job_dispatcher_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  job_t          din,
    input  logic          pop,
    output job_t          dout,
    output logic          ready,
    output logic          empty,
    output logic [LW-1:0] level,
    output logic [LW-1:0] level_next
);

    job_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_comb begin
        level_next = level + LW'(push) - LW'(pop);
    end

    assign empty = (level == '0);
    assign dout  = mem[rd_ptr];

    // ready is registered from the next occupancy so it is exact every cycle and 0 while in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ready  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level_next;
            ready <= (level_next < LW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/systolic_job_dispatcher.sv
// rtl/systolic_job_dispatcher.sv - queues matmul jobs and launches them one at a time into the systolic controller
// Purpose: accepts jobs on a valid/ready port, launches each with a 1-cycle new_data pulse, tracks done and
//          returns one status record per job (tag, cycles, overflow, error).
// Ports: clk, rst (async active-low); cmd_* host command port and cmd_tag; new_data/addr_A/B/C/n/stepping_enable
//        to the controller; done/total_cycles/overflow_out from the controller; sts_* status port; busy, level.
module systolic_job_dispatcher
    import systolic_job_dispatcher_pkg::*;
#(
    parameter int N       = 4,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [11:0]              cmd_addr_A,
    input  logic [11:0]              cmd_addr_B,
    input  logic [11:0]              cmd_addr_C,
    input  logic [8:0]               cmd_n,
    input  logic                     cmd_step,
    output logic [TAG_W-1:0]         cmd_tag,
    output logic                     new_data,
    output logic [11:0]              addr_A,
    output logic [11:0]              addr_B,
    output logic [11:0]              addr_C,
    output logic [8:0]               n,
    output logic                     stepping_enable,
    input  logic                     done,
    input  logic [15:0]              total_cycles,
    input  logic                     overflow_out,
    output logic                     sts_valid,
    input  logic                     sts_ready,
    output logic [TAG_W-1:0]         sts_tag,
    output logic [15:0]              sts_cycles,
    output logic                     sts_overflow,
    output logic [1:0]               sts_err,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    dispatch_state_t state;
    dispatch_state_t state_next;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_empty;
    logic [LW-1:0] level_next;
    job_t          push_job;
    job_t          head_job;
    logic          head_legal;
    logic          run_timeout;

    logic [TAG_W-1:0] cur_tag;
    logic [CW-1:0]    run_cnt;
    logic [15:0]      pend_cycles;
    logic             pend_ovf;
    logic [1:0]       pend_err;

    assign fifo_push = cmd_valid & cmd_ready;

    assign push_job = '{
        tag:    JOB_TAG_W'(cmd_tag),
        addr_a: cmd_addr_A,
        addr_b: cmd_addr_B,
        addr_c: cmd_addr_C,
        n:      cmd_n,
        step:   cmd_step
    };

    job_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .din        (push_job),
        .pop        (fifo_pop),
        .dout       (head_job),
        .ready      (cmd_ready),
        .empty      (fifo_empty),
        .level      (level),
        .level_next (level_next)
    );

    assign head_legal = n_is_legal(head_job.n, N);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= D_IDLE;
        else      state <= state_next;
    end

    // A new job is only popped while the status slot is empty; that is the status backpressure path.
    always_comb begin
        state_next  = state;
        fifo_pop    = 1'b0;
        run_timeout = 1'b0;
        case (state)
            D_IDLE: begin
                if (!fifo_empty && !sts_valid) begin
                    fifo_pop   = 1'b1;
                    state_next = head_legal ? D_LAUNCH : D_REPORT;
                end
            end
            D_LAUNCH:   state_next = D_WAIT_CLR;
            // The controller drops its sticky done one cycle after it samples new_data.
            D_WAIT_CLR: if (!done) state_next = D_RUN;
            D_RUN: begin
                if (done) begin
                    state_next = D_REPORT;
                end else if (!stepping_enable && run_cnt == CW'(TIMEOUT)) begin
                    run_timeout = 1'b1;
                    state_next  = D_REPORT;
                end
            end
            D_REPORT:   state_next = D_IDLE;
            default:    state_next = D_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_tag         <= '0;
            new_data        <= 1'b0;
            addr_A          <= '0;
            addr_B          <= '0;
            addr_C          <= '0;
            n               <= '0;
            stepping_enable <= 1'b0;
            sts_valid       <= 1'b0;
            sts_tag         <= '0;
            sts_cycles      <= '0;
            sts_overflow    <= 1'b0;
            sts_err         <= ERR_OK;
            busy            <= 1'b0;
            cur_tag         <= '0;
            run_cnt         <= '0;
            pend_cycles     <= '0;
            pend_ovf        <= 1'b0;
            pend_err        <= ERR_OK;
        end else begin
            if (fifo_push) cmd_tag <= cmd_tag + TAG_W'(1);
            new_data <= (state == D_LAUNCH);
            busy     <= (state_next != D_IDLE) || (level_next != '0);

            if (sts_valid && sts_ready) sts_valid <= 1'b0;

            case (state)
                D_IDLE: begin
                    if (fifo_pop) begin
                        addr_A          <= head_job.addr_a;
                        addr_B          <= head_job.addr_b;
                        addr_C          <= head_job.addr_c;
                        n               <= head_job.n;
                        stepping_enable <= head_job.step;
                        cur_tag         <= TAG_W'(head_job.tag);
                        pend_err        <= head_legal ? ERR_OK : ERR_BAD_N;
                        pend_cycles     <= '0;
                        pend_ovf        <= 1'b0;
                    end
                end
                D_WAIT_CLR: run_cnt <= '0;
                D_RUN: begin
                    if (~&run_cnt) run_cnt <= run_cnt + CW'(1);
                    if (done) begin
                        pend_cycles <= total_cycles;
                        pend_ovf    <= overflow_out;
                        pend_err    <= ERR_OK;
                    end else if (run_timeout) begin
                        pend_cycles <= '0;
                        pend_ovf    <= 1'b0;
                        pend_err    <= ERR_TIMEOUT;
                    end
                end
                D_REPORT: begin
                    sts_tag      <= cur_tag;
                    sts_cycles   <= pend_cycles;
                    sts_overflow <= pend_ovf;
                    sts_err      <= pend_err;
                    sts_valid    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_job_dispatcher.sv
// tb/tb_systolic_job_dispatcher.sv - directed scoreboard bench for systolic_job_dispatcher
module tb_systolic_job_dispatcher;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [11:0] cmd_addr_A = '0, cmd_addr_B = '0, cmd_addr_C = '0;
    logic [8:0]  cmd_n = '0;
    logic        cmd_step = 1'b0;
    logic [3:0]  cmd_tag;
    logic        new_data;
    logic [11:0] addr_A, addr_B, addr_C;
    logic [8:0]  n;
    logic        stepping_enable;
    logic        done = 1'b0;
    logic [15:0] total_cycles = '0;
    logic        overflow_out = 1'b0;
    logic        sts_valid;
    logic        sts_ready = 1'b0;
    logic [3:0]  sts_tag;
    logic [15:0] sts_cycles;
    logic        sts_overflow;
    logic [1:0]  sts_err;
    logic        busy;
    logic [2:0]  level;

    systolic_job_dispatcher #(.N(4), .DEPTH(4), .TAG_W(4), .TIMEOUT(1023)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr_A(cmd_addr_A), .cmd_addr_B(cmd_addr_B), .cmd_addr_C(cmd_addr_C),
        .cmd_n(cmd_n), .cmd_step(cmd_step), .cmd_tag(cmd_tag), .new_data(new_data),
        .addr_A(addr_A), .addr_B(addr_B), .addr_C(addr_C), .n(n), .stepping_enable(stepping_enable),
        .done(done), .total_cycles(total_cycles), .overflow_out(overflow_out),
        .sts_valid(sts_valid), .sts_ready(sts_ready), .sts_tag(sts_tag), .sts_cycles(sts_cycles),
        .sts_overflow(sts_overflow), .sts_err(sts_err), .busy(busy), .level(level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct packed {
        logic [3:0]  tag;
        logic [15:0] cycles;
        logic        ovf;
        logic [1:0]  err;
    } exp_t;

    exp_t sb[$];
    logic [3:0] tag_m = '0;
    int n_assert = 0;
    int n_fail = 0;
    int accept_cyc = 0;
    int sts_cyc = 0;

    // controller model: done drops right after launch, rises ctrl_delay cycles later unless ctrl_never
    int ctrl_delay = 40;
    logic [15:0] ctrl_cycles = 16'd57;
    logic ctrl_ovf = 1'b0;
    logic ctrl_never = 1'b0;
    int launches = 0;
    int launch_cyc = 0;
    int timer = 0;
    logic active = 1'b0;

    always @(negedge clk) begin
        if (new_data === 1'b1) begin
            launches++;
            launch_cyc = cyc;
            done = 1'b0;
            timer = ctrl_delay;
            active = !ctrl_never;
        end else if (active) begin
            timer--;
            if (timer <= 0) begin
                done = 1'b1;
                total_cycles = ctrl_cycles;
                overflow_out = ctrl_ovf;
                active = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_job(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c,
                            input logic [8:0] nn, input logic st,
                            input logic [15:0] ecyc, input logic eovf, input logic [1:0] eerr);
        int w = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr_A = a; cmd_addr_B = b; cmd_addr_C = c; cmd_n = nn; cmd_step = st;
        while (cmd_ready !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        check("push_accept", {31'd0, cmd_ready}, 32'd1);
        if (cmd_ready === 1'b1) begin
            check("cmd_tag", {28'd0, cmd_tag}, {28'd0, tag_m});
            @(posedge clk);
            #1;
            accept_cyc = cyc;
            sb.push_back('{tag: tag_m, cycles: ecyc, ovf: eovf, err: eerr});
            tag_m = tag_m + 4'd1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_status(input int budget);
        int w = 0;
        exp_t e;
        @(negedge clk);
        while (sts_valid !== 1'b1 && w < budget) begin
            @(negedge clk);
            w++;
        end
        check("sts_arrive", {31'd0, sts_valid}, 32'd1);
        if (sts_valid === 1'b1) begin
            sts_cyc = cyc;
            check("sb_nonempty", (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sts_tag", {28'd0, sts_tag}, {28'd0, e.tag});
                check("sts_cycles", {16'd0, sts_cycles}, {16'd0, e.cycles});
                check("sts_overflow", {31'd0, sts_overflow}, {31'd0, e.ovf});
                check("sts_err", {30'd0, sts_err}, {30'd0, e.err});
            end
            sts_ready = 1'b1;
            @(posedge clk);
            #1;
            sts_ready = 1'b0;
            @(negedge clk);
            check("sts_drop", {31'd0, sts_valid}, 32'd0);
        end
    endtask

    initial begin
        int base;
        int d;

        // 1. reset with cmd_valid held high
        rst = 1'b0;
        cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_new_data", {31'd0, new_data}, 32'd0);
        check("rst_sts_valid", {31'd0, sts_valid}, 32'd0);
        check("rst_level", {29'd0, level}, 32'd0);
        rst = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        // 2. single job, launch latency and status contents
        ctrl_delay = 40; ctrl_cycles = 16'd57; ctrl_ovf = 1'b0; ctrl_never = 1'b0;
        base = launches;
        push_job(12'd0, 12'd16, 12'd32, 9'd4, 1'b0, 16'd57, 1'b0, 2'b00);
        wait_status(200);
        check("launch_latency", launch_cyc - accept_cyc, 32'd2);
        check("single_launch_count", launches - base, 32'd1);
        check("latched_addr_B", {20'd0, addr_B}, 32'd16);
        check("latched_n", {23'd0, n}, 32'd4);

        // 3. fill with status held back; 6th job only fits after a status is taken
        ctrl_delay = 5; ctrl_cycles = 16'd23; ctrl_ovf = 1'b1;
        base = launches;
        for (int i = 0; i < 5; i++)
            push_job(12'(i), 12'(i + 100), 12'(i + 200), 9'(1 + (i % 4)), 1'b0, 16'd23, 1'b1, 2'b00);
        repeat (50) @(negedge clk);
        check("full_level", {29'd0, level}, 32'd4);
        check("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("backpressure_launches", launches - base, 32'd1);
        wait_status(10);
        push_job(12'd7, 12'd8, 12'd9, 9'd2, 1'b0, 16'd23, 1'b1, 2'b00);
        for (int i = 0; i < 5; i++) wait_status(200);
        check("fill_launches", launches - base, 32'd6);

        // 4. illegal sizes are reported without a launch
        ctrl_delay = 12; ctrl_cycles = 16'd99; ctrl_ovf = 1'b0;
        base = launches;
        push_job(12'd1, 12'd2, 12'd3, 9'd0, 1'b0, 16'd0, 1'b0, 2'b01);
        push_job(12'd1, 12'd2, 12'd3, 9'd5, 1'b0, 16'd0, 1'b0, 2'b01);
        push_job(12'd4, 12'd5, 12'd6, 9'd1, 1'b0, 16'd99, 1'b0, 2'b00);
        for (int i = 0; i < 3; i++) wait_status(200);
        check("bad_n_launches", launches - base, 32'd1);

        // 5. timeout, then stepping mode never times out
        ctrl_never = 1'b1;
        push_job(12'd10, 12'd11, 12'd12, 9'd3, 1'b0, 16'd0, 1'b0, 2'b10);
        wait_status(1200);
        d = sts_cyc - launch_cyc;
        check("timeout_latency", (d >= 1023 && d <= 1030) ? 32'd1 : 32'd0, 32'd1);
        push_job(12'd20, 12'd21, 12'd22, 9'd3, 1'b1, 16'd0, 1'b0, 2'b00);
        repeat (2000) @(negedge clk);
        check("step_no_status", {31'd0, sts_valid}, 32'd0);
        check("step_busy", {31'd0, busy}, 32'd1);

        // 6. asynchronous reset mid-RUN with two jobs queued
        push_job(12'd30, 12'd31, 12'd32, 9'd2, 1'b0, 16'd0, 1'b0, 2'b00);
        push_job(12'd40, 12'd41, 12'd42, 9'd2, 1'b0, 16'd0, 1'b0, 2'b00);
        @(negedge clk);
        check("queued_level", {29'd0, level}, 32'd2);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_level", {29'd0, level}, 32'd0);
        check("arst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_stepping", {31'd0, stepping_enable}, 32'd0);
        check("arst_addr_A", {20'd0, addr_A}, 32'd0);
        sb.delete();
        tag_m = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        ctrl_never = 1'b0; ctrl_delay = 10; ctrl_cycles = 16'd7; ctrl_ovf = 1'b0;
        push_job(12'd50, 12'd51, 12'd52, 9'd4, 1'b0, 16'd7, 1'b0, 2'b00);
        wait_status(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
